load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the RV32I core's memory stage and zeroDelayRAM, on the data port.
- Converts core byte/halfword/word load-store requests into word-aligned RAM accesses.
- Loads: sign- or zero-extends the selected lane. SB/SH: performs a read-modify-write. Misaligned or illegal requests are flagged and never reach RAM.
- Little-endian. Reads from zeroDelayRAM are combinational; its writes commit on the rising clock edge.

Parameters:
dataW, 32, data word width (fixed at 32 for RV32I)
RAMAddrSize, 32, byte address width to RAM

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  core request, sampled only when ready=1
isStore  in  1  1=store, 0=load
funct3  in  3  RV32I width/sign code
Addr  in  RAMAddrSize  byte address
WData  in  dataW  store data, lane-aligned in the LSBs
ready  out  1  1 when in IDLE and able to accept
done  out  1  one-cycle completion pulse
fault  out  1  valid with done; misaligned or illegal funct3
LoadData  out  dataW  extended load result, valid from done onward
RAMAddr  out  RAMAddrSize  word-aligned byte address to RAM
DataIn  out  dataW  write word to RAM
RAMWriteControl  out  1  RAM write enable
RAMOut  in  dataW  combinational RAM read word

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset state (reset=0): state=IDLE, ready=1, done=0, fault=0, LoadData=0, RAMAddr=0, DataIn=0, RAMWriteControl=0.
- States: IDLE, ACCESS, WRITE, DONE.
- IDLE: ready=1. On an edge with req=1, latch Addr, WData, funct3 and isStore.
  - Legal request -> ACCESS.
  - Fault -> DONE with fault=1. No RAM cycle is issued.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW.
- Any other funct3 is a fault.
- Misalignment faults:
  - halfword with Addr[0]=1
  - word with Addr[1:0]!=0
- ACCESS: RAMAddr={latched Addr[31:2],2'b00}.
  - Load: at the edge, LoadData is loaded with the lane selected by Addr[1:0] from RAMOut, sign- or zero-extended. Next state DONE.
  - SW: RAMWriteControl=1 and DataIn=WData, so the RAM commits at the ACCESS->DONE edge.
  - SB/SH: RAMWriteControl=0. At the edge, the merge register captures RAMOut with the target byte/halfword replaced by WData[7:0]/[15:0]. Next state WRITE.
- WRITE: RAMAddr unchanged, DataIn=merge register, RAMWriteControl=1. Next state DONE.
- DONE: done=1 for exactly one cycle, ready=0, then IDLE.
  - fault=1 only in a faulting DONE cycle.
  - LoadData holds until the next load completes. Stores and faults leave it unchanged.
- Latency (accept edge to done high):
  - load and SW: 2 cycles
  - SB/SH: 3 cycles
  - fault: 1 cycle
- Back-to-back: ready returns in the cycle after DONE. req while ready=0 is ignored; the core must hold req until accepted.
- RAMWriteControl decodes from registered state only. It is never high in IDLE or DONE, and never high for a faulting or load request.
- Reset asserted mid-operation: immediate return to IDLE. RAMWriteControl drops asynchronously, so an in-flight write does not commit. No done pulse.
- RAMAddr and DataIn hold their last values while idle.

Test Plan:
- SW Addr=64, WData=0x8899AABB -> RAMWriteControl high 1 cycle with RAMAddr=64; done 2 cycles after accept; LW 64 then returns LoadData=0x8899AABB, fault=0.
- LB Addr=65 -> LoadData=0xFFFFFFAA. LBU Addr=65 -> 0x000000AA. LH Addr=66 -> 0xFFFF8899. LHU Addr=66 -> 0x00008899.
- SH Addr=66, WData=0xDEAD1234 -> one read cycle then one write cycle with DataIn=0x1234AABB; done 3 cycles after accept. SB Addr=64, WData=0x77 -> word becomes 0x1234AA77.
- LW Addr=66, SH Addr=65, and funct3=011 -> done+fault 1 cycle after accept; RAMWriteControl never asserted; word at 64 unchanged; LoadData unchanged.
- reset=0 during the WRITE state of SB Addr=68 (word at 68 preset 0x11223344, WData=0x99) -> RAMWriteControl falls immediately, word at 68 still 0x11223344, no done, ready=1 after release.
- Back-to-back: SW then LW with req held high -> second request accepted in the cycle ready rises; no request dropped or duplicated.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store adapter between the RV32I memory stage and a
// word-addressed zero-delay RAM; sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   isStore,
    input  logic [2:0]             funct3,
    input  logic [RAMAddrSize-1:0] Addr,
    input  logic [dataW-1:0]       WData,
    output logic                   ready,
    output logic                   done,
    output logic                   fault,
    output logic [dataW-1:0]       LoadData,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       DataIn,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMOut
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    state_t                   state, state_nxt;
    logic                     req_fault;
    logic                     accept;
    logic                     fault_r;
    logic                     store_r;
    logic [2:0]               f3_r;
    logic [1:0]               off_r;
    logic [15:0]              wdata_r;
    logic [dataW-1:0]         load_data_r;
    logic [dataW-1:0]         data_in_r;
    logic [RAMAddrSize-1:0]   ram_addr_r;

    function automatic logic [dataW-1:0] load_extend(input logic [dataW-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [dataW-1:0]   r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{(dataW-8){b[7]}}, b};
            3'b100:  r = {{(dataW-8){1'b0}}, b};
            3'b001:  r = {{(dataW-16){h[15]}}, h};
            3'b101:  r = {{(dataW-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [dataW-1:0] merge_store(input logic [dataW-1:0] word,
                                                     input logic [15:0] wd,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
        logic [dataW-1:0] r;
        r = word;
        if (f3 == 3'b000) begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = wd;
        end else begin
            r[15:0] = wd;
        end
        return r;
    endfunction

    // Request legality: funct3 decode plus natural alignment.
    always_comb begin
        req_fault = 1'b1;
        case (funct3)
            3'b000:  req_fault = 1'b0;
            3'b001:  req_fault = Addr[0];
            3'b010:  req_fault = |Addr[1:0];
            3'b100:  req_fault = isStore;
            3'b101:  req_fault = isStore | Addr[0];
            default: req_fault = 1'b1;
        endcase
    end

    assign accept = (state == IDLE) && req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        ready           = 1'b0;
        done            = 1'b0;
        fault           = 1'b0;
        RAMWriteControl = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) state_nxt = req_fault ? DONE : ACCESS;
            end
            ACCESS: begin
                RAMWriteControl = store_r && (f3_r == 3'b010);
                state_nxt       = (store_r && (f3_r != 3'b010)) ? WRITE : DONE;
            end
            WRITE: begin
                RAMWriteControl = 1'b1;
                state_nxt       = DONE;
            end
            default: begin
                done      = 1'b1;
                fault     = fault_r;
                state_nxt = IDLE;
            end
        endcase
    end

    // Request fields only matter after acceptance, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            store_r <= isStore;
            f3_r    <= funct3;
            off_r   <= Addr[1:0];
            wdata_r <= WData[15:0];
        end
    end

    // data_in_r doubles as the merge register for sub-word stores.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_r     <= 1'b0;
            load_data_r <= '0;
            data_in_r   <= '0;
            ram_addr_r  <= '0;
        end else begin
            if (accept) begin
                fault_r <= req_fault;
                if (!req_fault) begin
                    ram_addr_r <= {Addr[RAMAddrSize-1:2], 2'b00};
                    if (isStore && (funct3 == 3'b010)) data_in_r <= WData;
                end
            end
            if (state == ACCESS) begin
                if (!store_r)
                    load_data_r <= load_extend(RAMOut, f3_r, off_r);
                else if (f3_r != 3'b010)
                    data_in_r <= merge_store(RAMOut, wdata_r, f3_r, off_r);
            end
        end
    end

    assign LoadData = load_data_r;
    assign RAMAddr  = ram_addr_r;
    assign DataIn   = data_in_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small zero-delay word RAM model.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        ready;
    logic        done;
    logic        fault;
    logic [31:0] LoadData;
    logic [31:0] RAMAddr;
    logic [31:0] DataIn;
    logic        RAMWriteControl;
    logic [31:0] RAMOut;

    logic [31:0] mem [0:255];
    int          wr_count;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    int nvec;
    int nerr;

    load_store_unit #(.dataW(32), .RAMAddrSize(32)) dut (
        .clock(clock), .reset(reset), .req(req), .isStore(isStore), .funct3(funct3),
        .Addr(Addr), .WData(WData), .ready(ready), .done(done), .fault(fault),
        .LoadData(LoadData), .RAMAddr(RAMAddr), .DataIn(DataIn),
        .RAMWriteControl(RAMWriteControl), .RAMOut(RAMOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign RAMOut = mem[RAMAddr[9:2]];

    initial begin
        wr_count   = 0;
        last_waddr = '0;
        last_wdata = '0;
    end

    always @(posedge clock) begin
        if (RAMWriteControl) begin
            mem[RAMAddr[9:2]] <= DataIn;
            wr_count          <= wr_count + 1;
            last_waddr        <= RAMAddr;
            last_wdata        <= DataIn;
        end
    end

    // Issue one request from IDLE; lat counts edges from the accept edge (=1) to done.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output int nwr,
                          output logic flt);
        int w0;
        @(negedge clock);
        isStore = st;
        funct3  = f3;
        Addr    = a;
        WData   = wd;
        req     = 1'b1;
        w0      = wr_count;
        @(posedge clock);
        #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!done) lat = 99;
        flt = fault;
        @(posedge clock);
        #1;
        nwr = wr_count - w0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        req     = 1'b0;
        isStore = 1'b0;
        funct3  = 3'b000;
        Addr    = '0;
        WData   = '0;
        #12;
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b expected 1", ready); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", done); end
        nvec++; if (fault !== 1'b0) begin nerr++; $display("FAIL reset_fault: got %b expected 0", fault); end
        nvec++; if (LoadData !== 32'h0) begin nerr++; $display("FAIL reset_loaddata: got %h expected 0", LoadData); end
        nvec++; if (RAMAddr !== 32'h0) begin nerr++; $display("FAIL reset_ramaddr: got %h expected 0", RAMAddr); end
        nvec++; if (DataIn !== 32'h0) begin nerr++; $display("FAIL reset_datain: got %h expected 0", DataIn); end
        nvec++; if (RAMWriteControl !== 1'b0) begin nerr++; $display("FAIL reset_we: got %b expected 0", RAMWriteControl); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_sw_lw();
        int lat, nwr;
        logic flt;
        do_req(1'b1, 3'b010, 32'd64, 32'h8899AABB, lat, nwr, flt);
        nvec++; if (lat !== 2) begin nerr++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        nvec++; if (nwr !== 1) begin nerr++; $display("FAIL sw_writes: got %0d expected 1", nwr); end
        nvec++; if (last_waddr !== 32'd64) begin nerr++; $display("FAIL sw_waddr: got %h expected 40", last_waddr); end
        nvec++; if (last_wdata !== 32'h8899AABB) begin nerr++; $display("FAIL sw_wdata: got %h expected 8899aabb", last_wdata); end
        nvec++; if (flt !== 1'b0) begin nerr++; $display("FAIL sw_fault: got %b expected 0", flt); end
        do_req(1'b0, 3'b010, 32'd64, 32'h0, lat, nwr, flt);
        nvec++; if (lat !== 2) begin nerr++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        nvec++; if (LoadData !== 32'h8899AABB) begin nerr++; $display("FAIL lw_data: got %h expected 8899aabb", LoadData); end
        nvec++; if (flt !== 1'b0) begin nerr++; $display("FAIL lw_fault: got %b expected 0", flt); end
        nvec++; if (nwr !== 0) begin nerr++; $display("FAIL lw_writes: got %0d expected 0", nwr); end
    endtask

    task automatic test_loads();
        int lat, nwr;
        logic flt;
        do_req(1'b0, 3'b000, 32'd65, 32'h0, lat, nwr, flt);
        nvec++; if (LoadData !== 32'hFFFFFFAA) begin nerr++; $display("FAIL lb_data: got %h expected ffffffaa", LoadData); end
        do_req(1'b0, 3'b100, 32'd65, 32'h0, lat, nwr, flt);
        nvec++; if (LoadData !== 32'h000000AA) begin nerr++; $display("FAIL lbu_data: got %h expected 000000aa", LoadData); end
        do_req(1'b0, 3'b001, 32'd66, 32'h0, lat, nwr, flt);
        nvec++; if (LoadData !== 32'hFFFF8899) begin nerr++; $display("FAIL lh_data: got %h expected ffff8899", LoadData); end
        do_req(1'b0, 3'b101, 32'd66, 32'h0, lat, nwr, flt);
        nvec++; if (LoadData !== 32'h00008899) begin nerr++; $display("FAIL lhu_data: got %h expected 00008899", LoadData); end
        nvec++; if (lat !== 2) begin nerr++; $display("FAIL lhu_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_subword_store();
        int lat, nwr;
        logic flt;
        do_req(1'b1, 3'b001, 32'd66, 32'hDEAD1234, lat, nwr, flt);
        nvec++; if (lat !== 3) begin nerr++; $display("FAIL sh_latency: got %0d expected 3", lat); end
        nvec++; if (nwr !== 1) begin nerr++; $display("FAIL sh_writes: got %0d expected 1", nwr); end
        nvec++; if (last_wdata !== 32'h1234AABB) begin nerr++; $display("FAIL sh_wdata: got %h expected 1234aabb", last_wdata); end
        nvec++; if (last_waddr !== 32'd64) begin nerr++; $display("FAIL sh_waddr: got %h expected 40", last_waddr); end
        nvec++; if (LoadData !== 32'h00008899) begin nerr++; $display("FAIL sh_loaddata_hold: got %h expected 00008899", LoadData); end
        do_req(1'b1, 3'b000, 32'd64, 32'h00000077, lat, nwr, flt);
        nvec++; if (lat !== 3) begin nerr++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        nvec++; if (last_wdata !== 32'h1234AA77) begin nerr++; $display("FAIL sb_wdata: got %h expected 1234aa77", last_wdata); end
        do_req(1'b0, 3'b010, 32'd64, 32'h0, lat, nwr, flt);
        nvec++; if (LoadData !== 32'h1234AA77) begin nerr++; $display("FAIL sb_readback: got %h expected 1234aa77", LoadData); end
    endtask

    task automatic test_faults();
        int lat, nwr;
        logic flt;
        do_req(1'b0, 3'b010, 32'd66, 32'h0, lat, nwr, flt);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL lw_mis_latency: got %0d expected 1", lat); end
        nvec++; if (flt !== 1'b1) begin nerr++; $display("FAIL lw_mis_fault: got %b expected 1", flt); end
        do_req(1'b1, 3'b001, 32'd65, 32'hFFFFFFFF, lat, nwr, flt);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL sh_mis_latency: got %0d expected 1", lat); end
        nvec++; if (flt !== 1'b1) begin nerr++; $display("FAIL sh_mis_fault: got %b expected 1", flt); end
        nvec++; if (nwr !== 0) begin nerr++; $display("FAIL sh_mis_writes: got %0d expected 0", nwr); end
        do_req(1'b0, 3'b011, 32'd64, 32'h0, lat, nwr, flt);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL f3_011_latency: got %0d expected 1", lat); end
        nvec++; if (flt !== 1'b1) begin nerr++; $display("FAIL f3_011_fault: got %b expected 1", flt); end
        nvec++; if (LoadData !== 32'h1234AA77) begin nerr++; $display("FAIL fault_loaddata_hold: got %h expected 1234aa77", LoadData); end
        do_req(1'b0, 3'b010, 32'd64, 32'h0, lat, nwr, flt);
        nvec++; if (LoadData !== 32'h1234AA77) begin nerr++; $display("FAIL fault_word_intact: got %h expected 1234aa77", LoadData); end
        nvec++; if (flt !== 1'b0) begin nerr++; $display("FAIL legal_after_fault: got %b expected 0", flt); end
    endtask

    task automatic test_reset_mid_write();
        int lat, nwr, w0;
        logic flt;
        do_req(1'b1, 3'b010, 32'd68, 32'h11223344, lat, nwr, flt);
        @(negedge clock);
        isStore = 1'b1;
        funct3  = 3'b000;
        Addr    = 32'd68;
        WData   = 32'h00000099;
        req     = 1'b1;
        @(posedge clock);
        #1;
        req = 1'b0;
        @(posedge clock);
        #1;
        nvec++; if (RAMWriteControl !== 1'b1) begin nerr++; $display("FAIL rst_write_state_we: got %b expected 1", RAMWriteControl); end
        nvec++; if (DataIn !== 32'h11223399) begin nerr++; $display("FAIL rst_merge_word: got %h expected 11223399", DataIn); end
        w0 = wr_count;
        #2;
        reset = 1'b0;
        #1;
        nvec++; if (RAMWriteControl !== 1'b0) begin nerr++; $display("FAIL rst_we_drop: got %b expected 0", RAMWriteControl); end
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b expected 1", ready); end
        @(posedge clock);
        #1;
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_no_done: got %b expected 0", done); end
        nvec++; if (wr_count !== w0) begin nerr++; $display("FAIL rst_no_commit: got %0d expected %0d", wr_count, w0); end
        nvec++; if (LoadData !== 32'h0) begin nerr++; $display("FAIL rst_loaddata: got %h expected 0", LoadData); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_after: got %b expected 1", ready); end
        do_req(1'b0, 3'b010, 32'd68, 32'h0, lat, nwr, flt);
        nvec++; if (LoadData !== 32'h11223344) begin nerr++; $display("FAIL rst_word_intact: got %h expected 11223344", LoadData); end
    endtask

    task automatic test_back_to_back();
        int   w0, ndone, naccept, acc_edge;
        logic rdy_before;
        @(negedge clock);
        isStore = 1'b1;
        funct3  = 3'b010;
        Addr    = 32'd72;
        WData   = 32'hCAFEF00D;
        req     = 1'b1;
        w0      = wr_count;
        @(posedge clock);
        #1;
        isStore  = 1'b0;
        WData    = 32'h0;
        ndone    = 0;
        naccept  = 0;
        acc_edge = 0;
        for (int i = 1; i <= 8; i++) begin
            rdy_before = ready;
            @(posedge clock);
            #1;
            if (rdy_before && req) begin
                naccept++;
                acc_edge = i;
                req = 1'b0;
            end
            if (done) ndone++;
        end
        nvec++; if (acc_edge !== 3) begin nerr++; $display("FAIL b2b_accept_edge: got %0d expected 3", acc_edge); end
        nvec++; if (naccept !== 1) begin nerr++; $display("FAIL b2b_accepts: got %0d expected 1", naccept); end
        nvec++; if (ndone !== 2) begin nerr++; $display("FAIL b2b_done_pulses: got %0d expected 2", ndone); end
        nvec++; if ((wr_count - w0) !== 1) begin nerr++; $display("FAIL b2b_writes: got %0d expected 1", wr_count - w0); end
        nvec++; if (LoadData !== 32'hCAFEF00D) begin nerr++; $display("FAIL b2b_loaddata: got %h expected cafef00d", LoadData); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_sw_lw();
        test_loads();
        test_subword_store();
        test_faults();
        test_reset_mid_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
